seg7_scan_decoder: RTL

Receive side of the multiplexed 7-segment display bus: samples the shared active-low segment lines and active-low digit-enable (anode) lines, and reconstructs one BCD digit per display position. Each digit is accepted only after a stability filter passes. Used by display self-check logic and by the verification loopback, where it sits directly on the segment/anode outputs of the display driver. Segment encoding is the team's standard: bit0=a … bit6=g, active-low (0 → 7'b1000000, 9 → 7'b0010000, blank → 7'b1111111).

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_to_bcd.sv | 36 +++
 rtl/seg7_scan_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns {g,f,e,d,c,b,a} and the
// receive-side scan state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        LATCHED = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational lookup from an active-low segment pattern to a BCD digit,
// flagging blank and unrecognised patterns.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_valid,
    output logic       o_is_blank,
    output logic [3:0] o_bcd
);

    // Pattern table lookup; anything outside the table is neither digit nor blank
    always_comb begin
        o_valid    = 1'b1;
        o_is_blank = 1'b0;
        o_bcd      = 4'hF;
        case (i_seg)
            SEG_0:     o_bcd = 4'd0;
            SEG_1:     o_bcd = 4'd1;
            SEG_2:     o_bcd = 4'd2;
            SEG_3:     o_bcd = 4'd3;
            SEG_4:     o_bcd = 4'd4;
            SEG_5:     o_bcd = 4'd5;
            SEG_6:     o_bcd = 4'd6;
            SEG_7:     o_bcd = 4'd7;
            SEG_8:     o_bcd = 4'd8;
            SEG_9:     o_bcd = 4'd9;
            SEG_BLANK: begin
                o_valid    = 1'b0;
                o_is_blank = 1'b1;
            end
            default:   o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: filters each scan slot for
// stability and reconstructs one BCD digit per display position.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     digit_upd,
    output logic                  err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int POS_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [6:0]            r_samp_seg;
    logic [DIGITS-1:0]     r_samp_an;
    logic [6:0]            r_prev_seg;
    logic [DIGITS-1:0]     r_prev_an;
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [DIGITS-1:0]     r_valid;
    logic [DIGITS-1:0]     r_upd;
    logic                  r_err;

    logic                  w_dec_valid;
    logic                  w_dec_blank;
    logic [3:0]            w_dec_bcd;
    logic [3:0]            w_zero_cnt;
    logic [POS_W-1:0]      w_pos;
    logic                  w_legal;
    logic                  w_same;
    logic [CNT_W-1:0]      w_cnt_inc;

    seg7_to_bcd u_dec (
        .i_seg      (r_samp_seg),
        .o_valid    (w_dec_valid),
        .o_is_blank (w_dec_blank),
        .o_bcd      (w_dec_bcd)
    );

    // Slot legality (exactly one anode low) and index of the active position
    always_comb begin
        w_zero_cnt = 4'd0;
        w_pos      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_zero_cnt = w_zero_cnt + {3'b000, ~r_samp_an[i]};
            w_pos      = r_samp_an[i] ? w_pos : POS_W'(i);
        end
        w_legal   = (w_zero_cnt == 4'd1);
        w_same    = (r_samp_seg == r_prev_seg) && (r_samp_an == r_prev_an);
        w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);
    end

    // Input sample pipeline feeding the stability comparison
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp_seg <= SEG_BLANK;
            r_samp_an  <= '1;
            r_prev_seg <= SEG_BLANK;
            r_prev_an  <= '1;
        end else begin
            r_samp_seg <= seg_in;
            r_samp_an  <= an_in;
            r_prev_seg <= r_samp_seg;
            r_prev_an  <= r_samp_an;
        end
    end

    // Stability filter FSM with registered digit writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bcd   <= '1;
            r_valid <= '0;
            r_upd   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_upd <= '0;
            r_err <= 1'b0;
            if (!w_legal) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= SETTLE;
                        r_cnt   <= CNT_ONE;
                    end
                    SETTLE: begin
                        if (!w_same) begin
                            r_cnt <= CNT_ONE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_MAX) begin
                                r_state              <= LATCHED;
                                r_bcd[w_pos*4 +: 4]  <= w_dec_valid ? w_dec_bcd : 4'hF;
                                r_valid[w_pos]       <= w_dec_valid;
                                r_upd[w_pos]         <= 1'b1;
                                r_err                <= !w_dec_valid && !w_dec_blank;
                            end
                        end
                    end
                    LATCHED: begin
                        if (!w_same) begin
                            r_state <= SETTLE;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bcd_out     = r_bcd;
    assign digit_valid = r_valid;
    assign digit_upd   = r_upd;
    assign err         = r_err;

endmodule
